// File: rtl/pipe_pkg.sv
// Shared pipeline types: stage-slot record, forwarding select codes and a
// small helper for register-match tests against the ID sources.
package pipe_pkg;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use_rs1;
      logic       use_rs2;
      logic       regwrite;
      logic       memread;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '0;

   // True when a nonzero destination matches either used source; x0 never hits.
   function automatic logic rd_hits(input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic use1,
                                    input logic [4:0] rs2, input logic use2);
      return (rd != 5'd0) && ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
   endfunction

endpackage

// File: rtl/fwd_select.sv
// EX-stage operand forwarding select for one source register.
module fwd_select
   import pipe_pkg::*;
(
   input  logic [4:0] rs,
   input  logic       use_rs,
   input  slot_t      mem_slot,
   input  slot_t      wb_slot,
   output logic [1:0] sel
);

   logic unused_fields;
   assign unused_fields = ^{mem_slot.rs1, mem_slot.rs2, mem_slot.use_rs1, mem_slot.use_rs2,
                            mem_slot.memread, wb_slot.rs1, wb_slot.rs2, wb_slot.use_rs1,
                            wb_slot.use_rs2, wb_slot.memread};

   // The younger producer (MEM) wins over WB when both write the same register.
   always_comb begin
      sel = FWD_REG;
      if (use_rs && mem_slot.valid && mem_slot.regwrite &&
          (mem_slot.rd != 5'd0) && (mem_slot.rd == rs)) begin
         sel = FWD_EXMEM;
      end else if (use_rs && wb_slot.valid && wb_slot.regwrite &&
                   (wb_slot.rd != 5'd0) && (wb_slot.rd == rs)) begin
         sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// Five-stage pipeline sequencing: freeze/stall/bubble/flush control from a
// shadow copy of the EX, MEM and WB instructions, plus EX forwarding selects.
module hazard_controller
   import pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic [4:0]       id_rd_i,
   input  logic             id_regwrite_i,
   input  logic             id_memread_i,
   input  logic             id_branch_i,
   input  logic             branch_taken_i,
   input  logic             mem_stall_i,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             pipe_freeze_o,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   slot_t            ex_reg, mem_reg, wb_reg;
   slot_t            ex_next;
   logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
   logic             load_use, branch_hazard, stall_event, flush_event;

   always_comb begin
      load_use      = ex_reg.valid && ex_reg.memread &&
                      rd_hits(ex_reg.rd, id_rs1_i, id_use_rs1_i, id_rs2_i, id_use_rs2_i);
      // Branches compare in ID, so they also wait for EX ALU results and MEM loads.
      branch_hazard = id_branch_i &&
                      ((ex_reg.valid && ex_reg.regwrite &&
                        rd_hits(ex_reg.rd, id_rs1_i, id_use_rs1_i, id_rs2_i, id_use_rs2_i)) ||
                       (mem_reg.valid && mem_reg.memread &&
                        rd_hits(mem_reg.rd, id_rs1_i, id_use_rs1_i, id_rs2_i, id_use_rs2_i)));
   end

   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_freeze_o = 1'b0;
      stall_event   = 1'b0;
      flush_event   = 1'b0;
      if (mem_stall_i) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         pipe_freeze_o = 1'b1;
         stall_event   = 1'b1;
      end else if (load_use || branch_hazard) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
         stall_event   = 1'b1;
      end else if (id_branch_i && branch_taken_i) begin
         ifid_flush_o  = 1'b1;
         flush_event   = 1'b1;
      end
   end

   always_comb begin
      ex_next = SLOT_EMPTY;
      if (!idex_bubble_o) begin
         ex_next.valid    = 1'b1;
         ex_next.rd       = id_rd_i;
         ex_next.rs1      = id_rs1_i;
         ex_next.rs2      = id_rs2_i;
         ex_next.use_rs1  = id_use_rs1_i;
         ex_next.use_rs2  = id_use_rs2_i;
         ex_next.regwrite = id_regwrite_i;
         ex_next.memread  = id_memread_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_reg        <= SLOT_EMPTY;
         mem_reg       <= SLOT_EMPTY;
         wb_reg        <= SLOT_EMPTY;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if (!pipe_freeze_o) begin
            ex_reg  <= ex_next;
            mem_reg <= ex_reg;
            wb_reg  <= mem_reg;
         end
         if (stall_event && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
         end
         if (flush_event && (flush_cnt_reg != CNT_MAX)) begin
            flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_reg;
   assign flush_cnt_o = flush_cnt_reg;

   logic [1:0][4:0] ex_src;
   logic [1:0]      ex_use;
   logic [1:0][1:0] fwd_sel;

   assign ex_src[0] = ex_reg.rs1;
   assign ex_src[1] = ex_reg.rs2;
   assign ex_use[0] = ex_reg.valid && ex_reg.use_rs1;
   assign ex_use[1] = ex_reg.valid && ex_reg.use_rs2;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         fwd_select u_fwd (
            .rs       (ex_src[gi]),
            .use_rs   (ex_use[gi]),
            .mem_slot (mem_reg),
            .wb_slot  (wb_reg),
            .sel      (fwd_sel[gi])
         );
      end
   endgenerate

   assign fwd_a_o = fwd_sel[0];
   assign fwd_b_o = fwd_sel[1];

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed instruction table, reset/saturation
// sequences, and randomized traffic against an in-flight instruction model.
module tb_hazard_controller;

   localparam logic [4:0] C_NORM  = 5'b11000;
   localparam logic [4:0] C_STALL = 5'b00010;
   localparam logic [4:0] C_FLUSH = 5'b11100;
   localparam logic [4:0] C_FRZ   = 5'b00001;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_use_rs1, id_use_rs2, id_regwrite, id_memread, id_branch, branch_taken, mem_stall;
   logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_cnt, flush_cnt;
   logic [8:0]  out_vec;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   hazard_controller #(.CNT_W(16)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .id_rs1_i       (id_rs1),
      .id_rs2_i       (id_rs2),
      .id_use_rs1_i   (id_use_rs1),
      .id_use_rs2_i   (id_use_rs2),
      .id_rd_i        (id_rd),
      .id_regwrite_i  (id_regwrite),
      .id_memread_i   (id_memread),
      .id_branch_i    (id_branch),
      .branch_taken_i (branch_taken),
      .mem_stall_i    (mem_stall),
      .pc_write_o     (pc_write),
      .ifid_write_o   (ifid_write),
      .ifid_flush_o   (ifid_flush),
      .idex_bubble_o  (idex_bubble),
      .pipe_freeze_o  (pipe_freeze),
      .fwd_a_o        (fwd_a),
      .fwd_b_o        (fwd_b),
      .stall_cnt_o    (stall_cnt),
      .flush_cnt_o    (flush_cnt)
   );

   assign out_vec = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, fwd_a, fwd_b};

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, rw, mr, br, tk, ms;
      logic [4:0] ctl;
      logic [1:0] fa, fb;
   } vec_t;

   typedef struct {
      bit v;
      int rd, rs1, rs2;
      bit u1, u2, rw, mr;
   } ins_t;

   vec_t tbl[$];
   ins_t m_pipe[3];   // in-flight instructions by age: 0 = EX, 1 = MEM, 2 = WB
   int   m_stall, m_flush;

   function automatic vec_t mk(input int rs1, input int u1, input int rs2, input int u2,
                               input int rd, input int rw, input int mr, input int br,
                               input int tk, input int ms,
                               input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
      vec_t v;
      v.rs1 = 5'(rs1); v.u1 = 1'(u1); v.rs2 = 5'(rs2); v.u2 = 1'(u2); v.rd = 5'(rd);
      v.rw = 1'(rw); v.mr = 1'(mr); v.br = 1'(br); v.tk = 1'(tk); v.ms = 1'(ms);
      v.ctl = ctl; v.fa = fa; v.fb = fb;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      id_rs1 = v.rs1; id_use_rs1 = v.u1; id_rs2 = v.rs2; id_use_rs2 = v.u2; id_rd = v.rd;
      id_regwrite = v.rw; id_memread = v.mr; id_branch = v.br; branch_taken = v.tk;
      mem_stall = v.ms;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic bit id_reads(input int r);
      return (r != 0) && ((id_use_rs1 && int'(id_rs1) == r) || (id_use_rs2 && int'(id_rs2) == r));
   endfunction

   function automatic logic [1:0] m_fwd(input int src, input bit used);
      if (!used) return 2'b00;
      for (int age = 1; age <= 2; age++) begin
         if (m_pipe[age].v && m_pipe[age].rw && m_pipe[age].rd != 0 && m_pipe[age].rd == src)
            return (age == 1) ? 2'b10 : 2'b01;
      end
      return 2'b00;
   endfunction

   function automatic logic [4:0] m_ctl();
      bit lu, bh;
      lu = m_pipe[0].v && m_pipe[0].mr && id_reads(m_pipe[0].rd);
      bh = id_branch && ((m_pipe[0].v && m_pipe[0].rw && id_reads(m_pipe[0].rd)) ||
                         (m_pipe[1].v && m_pipe[1].mr && id_reads(m_pipe[1].rd)));
      if (mem_stall) return C_FRZ;
      if (lu || bh) return C_STALL;
      if (id_branch && branch_taken) return C_FLUSH;
      return C_NORM;
   endfunction

   task automatic m_clear();
      for (int k = 0; k < 3; k++) m_pipe[k] = '{default: 0};
      m_stall = 0;
      m_flush = 0;
   endtask

   task automatic m_edge(input logic [4:0] ctl);
      ins_t n;
      if (rst) begin
         m_clear();
         return;
      end
      if (ctl == C_STALL || ctl == C_FRZ) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if (ctl == C_FLUSH) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
      if (ctl != C_FRZ) begin
         n = '{default: 0};
         if (ctl != C_STALL) begin
            n.v = 1; n.rd = int'(id_rd); n.rs1 = int'(id_rs1); n.rs2 = int'(id_rs2);
            n.u1 = id_use_rs1; n.u2 = id_use_rs2; n.rw = id_regwrite; n.mr = id_memread;
         end
         m_pipe[2] = m_pipe[1];
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = n;
      end
   endtask

   initial begin
      int   exp_stall, exp_flush;
      vec_t nop_v, lw5, add5;
      nop_v = mk(0,0,0,0,0,0,0,0,0,0, C_NORM, 2'b00, 2'b00);
      lw5   = mk(1,1,0,0,5,1,1,0,0,0, C_NORM, 2'b00, 2'b00);
      add5  = mk(5,1,2,1,6,1,0,0,0,0, C_STALL, 2'b00, 2'b00);

      // load-use
      tbl.push_back(lw5);
      tbl.push_back(add5);
      tbl.push_back(mk(5,1,2,1,6,1,0,0,0,0, C_NORM, 2'b00, 2'b00));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, C_NORM, 2'b01, 2'b00));
      tbl.push_back(nop_v);
      tbl.push_back(nop_v);
      // back-to-back ALU
      tbl.push_back(mk(1,1,2,1,3,1,0,0,0,0, C_NORM, 2'b00, 2'b00));
      tbl.push_back(mk(3,1,3,1,4,1,0,0,0,0, C_NORM, 2'b00, 2'b00));
      tbl.push_back(mk(3,1,0,1,7,1,0,0,0,0, C_NORM, 2'b10, 2'b10));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, C_NORM, 2'b01, 2'b00));
      tbl.push_back(nop_v);
      // x0 suppression, including a load into x0
      tbl.push_back(mk(0,1,0,0,0,1,0,0,0,0, C_NORM, 2'b00, 2'b00));
      tbl.push_back(mk(0,1,0,1,1,1,0,0,0,0, C_NORM, 2'b00, 2'b00));
      tbl.push_back(nop_v);
      tbl.push_back(nop_v);
      tbl.push_back(mk(1,1,0,0,0,1,1,0,0,0, C_NORM, 2'b00, 2'b00));
      tbl.push_back(mk(0,1,0,1,1,1,0,0,0,0, C_NORM, 2'b00, 2'b00));
      tbl.push_back(nop_v);
      tbl.push_back(nop_v);
      tbl.push_back(nop_v);
      // taken branch, independent operands
      tbl.push_back(mk(1,1,2,1,0,0,0,1,1,0, C_FLUSH, 2'b00, 2'b00));
      tbl.push_back(nop_v);
      tbl.push_back(nop_v);
      tbl.push_back(nop_v);
      // branch after load: two stalls then flush
      tbl.push_back(lw5);
      tbl.push_back(mk(5,1,0,1,0,0,0,1,1,0, C_STALL, 2'b00, 2'b00));
      tbl.push_back(mk(5,1,0,1,0,0,0,1,1,0, C_STALL, 2'b00, 2'b00));
      tbl.push_back(mk(5,1,0,1,0,0,0,1,1,0, C_FLUSH, 2'b00, 2'b00));
      tbl.push_back(nop_v);
      tbl.push_back(nop_v);
      // freeze over a pending load-use
      tbl.push_back(lw5);
      for (int k = 0; k < 3; k++) tbl.push_back(mk(5,1,2,1,6,1,0,0,0,1, C_FRZ, 2'b00, 2'b00));
      tbl.push_back(add5);
      tbl.push_back(mk(5,1,2,1,6,1,0,0,0,0, C_NORM, 2'b00, 2'b00));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, C_NORM, 2'b01, 2'b00));

      rst = 1'b1;
      drive(nop_v);
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", 32'(out_vec), 32'({C_NORM, 2'b00, 2'b00}));
      check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
      check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
      rst = 1'b0;

      exp_stall = 0;
      exp_flush = 0;
      foreach (tbl[i]) begin
         drive(tbl[i]);
         #1;
         check($sformatf("row%0d_out", i), 32'(out_vec), 32'({tbl[i].ctl, tbl[i].fa, tbl[i].fb}));
         check($sformatf("row%0d_stall_cnt", i), 32'(stall_cnt), 32'(exp_stall));
         check($sformatf("row%0d_flush_cnt", i), 32'(flush_cnt), 32'(exp_flush));
         $display("row %0d out=%b stall_cnt=%0d flush_cnt=%0d", i, out_vec, stall_cnt, flush_cnt);
         if (tbl[i].ctl == C_STALL || tbl[i].ctl == C_FRZ) exp_stall++;
         if (tbl[i].ctl == C_FLUSH) exp_flush++;
         @(posedge clk);
         #1;
      end
      check("table_final_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      check("table_final_flush_cnt", 32'(flush_cnt), 32'(exp_flush));

      // reset asserted during a load-use stall
      drive(lw5);
      @(posedge clk);
      #1;
      drive(add5);
      #1;
      check("pre_reset_stall", 32'(out_vec), 32'({C_STALL, 2'b00, 2'b00}));
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midstall_reset_out", 32'(out_vec), 32'({C_NORM, 2'b00, 2'b00}));
      check("midstall_reset_stall_cnt", 32'(stall_cnt), 32'd0);
      check("midstall_reset_flush_cnt", 32'(flush_cnt), 32'd0);
      $display("reset during stall out=%b stall_cnt=%0d", out_vec, stall_cnt);
      rst = 1'b0;

      // counter saturation: preload to 0xFFFE with freezes, then three more stalls
      drive(mk(0,0,0,0,0,0,0,0,0,1, C_FRZ, 2'b00, 2'b00));
      repeat (65534) @(posedge clk);
      #1;
      check("preload_stall_cnt", 32'(stall_cnt), 32'hFFFE);
      drive(lw5);
      @(posedge clk);
      #1;
      drive(add5);
      #1;
      check("sat_load_use_stall", 32'(out_vec), 32'({C_STALL, 2'b00, 2'b00}));
      @(posedge clk);
      #1;
      check("sat_first_stall_cnt", 32'(stall_cnt), 32'hFFFF);
      mem_stall = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("sat_hold_stall_cnt", 32'(stall_cnt), 32'hFFFF);
      $display("saturation stall_cnt=%h", stall_cnt);

      // randomized traffic against the in-flight model
      drive(nop_v);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_clear();
      for (int n = 0; n < 600; n++) begin
         vec_t       v;
         logic [4:0] ectl;
         logic [1:0] efa, efb;
         v = mk(int'($urandom_range(0,3)), int'($urandom_range(0,1)),
                int'($urandom_range(0,3)), int'($urandom_range(0,1)),
                int'($urandom_range(0,3)), int'($urandom_range(0,1)),
                int'($urandom_range(0,2) == 0), int'($urandom_range(0,3) == 0),
                int'($urandom_range(0,1)), int'($urandom_range(0,9) == 0),
                C_NORM, 2'b00, 2'b00);
         drive(v);
         rst = ($urandom_range(0,99) == 0);
         #1;
         ectl = m_ctl();
         efa  = m_fwd(m_pipe[0].rs1, m_pipe[0].v && m_pipe[0].u1);
         efb  = m_fwd(m_pipe[0].rs2, m_pipe[0].v && m_pipe[0].u2);
         check($sformatf("rand%0d_out", n), 32'(out_vec), 32'({ectl, efa, efb}));
         check($sformatf("rand%0d_stall_cnt", n), 32'(stall_cnt), 32'(m_stall));
         check($sformatf("rand%0d_flush_cnt", n), 32'(flush_cnt), 32'(m_flush));
         $display("rand %0d rst=%0d out=%b stall_cnt=%0d flush_cnt=%0d", n, rst, out_vec,
                  stall_cnt, flush_cnt);
         @(posedge clk);
         m_edge(ectl);
         #1;
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
